// File: rtl/video_std_pkg.sv
// Shared types, force-mode encodings and default thresholds for the video
// standard lock controller.
package video_std_pkg;

  typedef enum logic [1:0] {
    STD_NTSC = 2'd0,
    STD_PAL  = 2'd1,
    STD_BAD  = 2'd2
  } std_t;

  typedef enum logic [1:0] {
    ST_NO_SIG  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0] FORCE_AUTO     = 2'b00;
  localparam logic [1:0] FORCE_NTSC     = 2'b01;
  localparam logic [1:0] FORCE_PAL      = 2'b10;
  localparam logic [1:0] FORCE_AUTO_ALT = 2'b11;

  localparam int DEF_CONFIRM_FRAMES = 4;
  localparam int DEF_TIMEOUT_TICKS  = 40;
  localparam int DEF_NTSC_MIN       = 19;
  localparam int DEF_NTSC_MAX       = 23;
  localparam int DEF_PAL_MIN        = 24;
  localparam int DEF_PAL_MAX        = 27;

  // Map a measured frame length onto a standard; windows are inclusive.
  function automatic std_t classify(input logic [4:0] count,
                                    input logic [4:0] ntsc_min,
                                    input logic [4:0] ntsc_max,
                                    input logic [4:0] pal_min,
                                    input logic [4:0] pal_max);
    if (count >= ntsc_min && count <= ntsc_max) return STD_NTSC;
    if (count >= pal_min && count <= pal_max)   return STD_PAL;
    return STD_BAD;
  endfunction

  // Saturating 4-bit increment so frame counters never wrap.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/vsync_watchdog.sv
// Counts prescaler ticks since the last frame measurement and flags the
// cycle in which the count reaches the timeout limit.
module vsync_watchdog
  import video_std_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic clk_10k,
  input  logic rst_n,
  input  logic tick,
  input  logic meas_valid,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_TICKS);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // A measurement clears the count even on a tick; otherwise count up and hold at the limit.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (meas_valid) begin
      cnt_d = '0;
    end else if (tick && (cnt_q < LIMIT)) begin
      cnt_d  = cnt_q + 8'd1;
      expire = (cnt_q == (LIMIT - 8'd1));
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_std_lock_ctrl.sv
// Classifies measured frame periods as NTSC/PAL, locks onto a standard after
// enough agreeing frames, drops lock on repeated misses or signal loss, and
// publishes the effective (possibly forced) standard.
module video_std_lock_ctrl
  import video_std_pkg::*;
#(
  parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES,
  parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS,
  parameter int NTSC_MIN       = DEF_NTSC_MIN,
  parameter int NTSC_MAX       = DEF_NTSC_MAX,
  parameter int PAL_MIN        = DEF_PAL_MIN,
  parameter int PAL_MAX        = DEF_PAL_MAX
) (
  input  logic       clk_10k,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       meas_valid,
  input  logic [4:0] meas_count,
  input  logic [1:0] force_mode,
  output logic       is_pal,
  output logic       is_ntsc,
  output logic       locked,
  output logic       no_signal,
  output logic       std_changed
);

  localparam logic [3:0] CONFIRM = 4'(CONFIRM_FRAMES);
  localparam logic [4:0] N_MIN   = 5'(NTSC_MIN);
  localparam logic [4:0] N_MAX   = 5'(NTSC_MAX);
  localparam logic [4:0] P_MIN   = 5'(PAL_MIN);
  localparam logic [4:0] P_MAX   = 5'(PAL_MAX);

  state_t     state_q, state_d;
  std_t       cand_q, cand_d;
  std_t       lock_std_q, lock_std_d;
  logic [3:0] agree_q, agree_d;
  logic [3:0] miss_q, miss_d;
  logic       eff_pal_q, eff_pal_d;
  logic       std_changed_q, std_changed_d;
  logic       first_q;
  logic       expire;
  std_t       frame_std;
  logic [3:0] agree_inc;
  logic [3:0] miss_inc;

  vsync_watchdog #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_watchdog (
    .clk_10k   (clk_10k),
    .rst_n     (rst_n),
    .tick      (tick),
    .meas_valid(meas_valid),
    .expire    (expire)
  );

  assign frame_std = classify(meas_count, N_MIN, N_MAX, P_MIN, P_MAX);
  assign agree_inc = sat_inc4(agree_q);
  assign miss_inc  = sat_inc4(miss_q);

  // Lock FSM: a measurement always takes priority over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    lock_std_d = lock_std_q;
    agree_d    = agree_q;
    miss_d     = miss_q;
    if (meas_valid) begin
      unique case (state_q)
        ST_NO_SIG: begin
          if (frame_std != STD_BAD) begin
            state_d = ST_ACQUIRE;
            cand_d  = frame_std;
            agree_d = 4'd1;
          end
        end
        ST_ACQUIRE: begin
          if (frame_std == cand_q) begin
            agree_d = agree_inc;
            if (agree_inc >= CONFIRM) begin
              state_d    = ST_LOCKED;
              lock_std_d = cand_q;
              miss_d     = '0;
            end
          end else if (frame_std != STD_BAD) begin
            cand_d  = frame_std;
            agree_d = 4'd1;
          end else begin
            agree_d = '0;
          end
        end
        ST_LOCKED: begin
          if (frame_std == lock_std_q) begin
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc >= CONFIRM) begin
              state_d = ST_ACQUIRE;
              agree_d = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_NO_SIG;
      endcase
    end else if (expire) begin
      state_d = ST_NO_SIG;
      agree_d = '0;
      miss_d  = '0;
    end
  end

  // Effective standard follows the next lock value so lock and output move together.
  always_comb begin
    eff_pal_d = (lock_std_d == STD_PAL);
    if (force_mode == FORCE_NTSC)     eff_pal_d = 1'b0;
    else if (force_mode == FORCE_PAL) eff_pal_d = 1'b1;
    std_changed_d = !first_q && (eff_pal_d != eff_pal_q);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_NO_SIG;
      cand_q        <= STD_NTSC;
      lock_std_q    <= STD_NTSC;
      agree_q       <= '0;
      miss_q        <= '0;
      eff_pal_q     <= 1'b0;
      std_changed_q <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      lock_std_q    <= lock_std_d;
      agree_q       <= agree_d;
      miss_q        <= miss_d;
      eff_pal_q     <= eff_pal_d;
      std_changed_q <= std_changed_d;
      first_q       <= 1'b0;
    end
  end

  assign is_pal      = eff_pal_q;
  assign is_ntsc     = !eff_pal_q;
  assign locked      = (state_q == ST_LOCKED);
  assign no_signal   = (state_q == ST_NO_SIG);
  assign std_changed = std_changed_q;

endmodule

// File: doc/video_std_lock_ctrl.md
VIDEO_STD_LOCK_CTRL -- requirements
Module: video_std_lock_ctrl

Interface
REQ-001 CONFIRM_FRAMES, 4, consecutive agreeing frames to lock; also consecutive bad frames to drop lock (range 2..15).
REQ-002 TIMEOUT_TICKS, 40, 1.25 kHz ticks without a measurement before NO_SIG (range 2..255).
REQ-003 NTSC_MIN/NTSC_MAX, 19/23, inclusive NTSC window for meas_count.
REQ-004 PAL_MIN/PAL_MAX, 24/27, inclusive PAL window for meas_count.
REQ-005 clk_10k  in  1  sole clock, 10 kHz.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 tick  in  1  one-cycle 1.25 kHz prescaler strobe.
REQ-008 meas_valid  in  1  one-cycle strobe; a frame period was measured (VSYNC falling edge).
REQ-009 meas_count  in  5  1.25 kHz pulses in the completed frame; qualified by meas_valid.
REQ-010 force_mode  in  2  00/11 auto, 01 force NTSC, 10 force PAL.
REQ-011 is_pal / is_ntsc  out  1 each  effective standard, always mutually exclusive.
REQ-012 locked  out  1  FSM in LOCKED.
REQ-013 no_signal  out  1  FSM in NO_SIG.
REQ-014 std_changed  out  1  one-cycle pulse when effective standard changes.

Function
REQ-015 Classification on meas_valid: count in NTSC window -> NTSC; in PAL window -> PAL; anything else, including 31, -> BAD.
REQ-016 FSM states are NO_SIG, ACQUIRE, LOCKED; all registered outputs update one clk_10k cycle after the triggering strobe.
REQ-017 NO_SIG: NTSC/PAL frame -> ACQUIRE, candidate = class, agree_cnt = 1; BAD frame -> stay.
REQ-018 ACQUIRE: frame matching candidate -> agree_cnt+1; reaching CONFIRM_FRAMES -> LOCKED, lock_std = candidate, miss_cnt = 0.
REQ-019 ACQUIRE: other valid class -> candidate = new class, agree_cnt = 1; BAD -> agree_cnt = 0, candidate kept.
REQ-020 LOCKED: frame matching lock_std -> miss_cnt = 0; mismatching or BAD -> miss_cnt+1; reaching CONFIRM_FRAMES -> ACQUIRE, agree_cnt = 0.
REQ-021 Watchdog: counts tick; cleared by meas_valid; meas_valid and tick in the same cycle -> clear wins.
REQ-022 Watchdog reaching TIMEOUT_TICKS -> NO_SIG from any state, counters zeroed, watchdog holds at TIMEOUT_TICKS until next meas_valid.
REQ-023 Timeout expiry and meas_valid in the same cycle -> meas_valid is processed, no timeout.
REQ-024 lock_std is retained through ACQUIRE and NO_SIG; it changes only on entry to LOCKED.
REQ-025 Effective standard = forced value when force_mode is 01/10, else lock_std; the FSM runs regardless of force_mode.
REQ-026 std_changed pulses for exactly one cycle whenever the effective standard differs from its previous-cycle value, whether caused by lock or force_mode.
REQ-027 All counters saturate and never wrap.

Reset
REQ-028 rst_n low -> state NO_SIG, lock_std NTSC, candidate NTSC, all counters 0, watchdog 0.
REQ-029 Outputs during and after reset: is_ntsc=1, is_pal=0 (auto), locked=0, no_signal=1, std_changed=0.
REQ-030 Reset asserted mid-acquire or mid-lock discards all progress; after reset release, no std_changed pulse is generated in the first cycle.

Structure
REQ-031 Package video_std_pkg holds the std_t enum (NTSC, PAL, BAD), the state_t enum, the force_mode encodings, and the default window constants.
REQ-032 Sub-module vsync_watchdog holds the tick counter and timeout flag; classifier and FSM stay in the top level.

Verification
REQ-033 Auto mode: 4 frames of count 25 -> locked=1 and is_pal=1 one cycle after the 4th meas_valid, with a single std_changed pulse.
REQ-034 Locked PAL, then 3 frames of count 20 -> still locked PAL; 4th frame -> locked=0, is_pal=1; 4 more frames of count 20 -> is_ntsc=1 with std_changed.
REQ-035 Locked, then 40 ticks with no meas_valid -> no_signal=1 and locked=0, standard unchanged; meas_valid coincident with the 40th tick -> no timeout.
REQ-036 Alternating frames 25, 20, 25, 20 -> never locked; a count of 31 resets agree_cnt.
REQ-037 force_mode 10 while locked NTSC -> is_pal=1 next cycle with std_changed; return to 00 -> is_ntsc=1 with std_changed.
REQ-038 rst_n pulsed low after 3 of 4 PAL frames -> outputs take reset values immediately; 4 fresh frames are needed to lock.
